// File: rtl/tt_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tt_input_debounce
// Description : Per-channel 2-flop synchronizer plus saturating debounce
//               counter. A changed level is accepted once it has persisted for
//               DEBOUNCE_CYCLES synchronized cycles. Optional registered
//               rise/fall pulses are built when DEBOUNCE_EDGE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_input_debounce #(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise,
    output logic [NUM_CH-1:0] fall,
    output logic [NUM_CH-1:0] busy
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]         r_sync;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_db;
        logic               r_busy;
        logic               w_diff;
        logic               w_accept;

        assign w_diff   = r_sync[1] ^ r_db;
        assign w_accept = w_diff && (r_cnt == c_CNT_MAX);

        // Any cycle where the synchronized level matches the accepted one
        // discards the pending change; acceptance also clears the counter,
        // so the counter saturates at c_CNT_MAX and never wraps.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= 2'b00;
                r_cnt  <= '0;
                r_db   <= 1'b0;
                r_busy <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], raw_in[i]};
                if (!w_diff || w_accept) begin
                    r_cnt  <= '0;
                    r_busy <= 1'b0;
                end else begin
                    r_cnt  <= r_cnt + c_CNT_ONE;
                    r_busy <= 1'b1;
                end
                if (w_accept) begin
                    r_db <= ~r_db;
                end
            end
        end

        assign db_out[i] = r_db;
        assign busy[i]   = r_busy;

`ifdef DEBOUNCE_EDGE_EN
        logic r_rise;
        logic r_fall;

        // Pulses register alongside the db_out flip so they line up with it.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
            end else begin
                r_rise <= w_accept && !r_db;
                r_fall <= w_accept && r_db;
            end
        end

        assign rise[i] = r_rise;
        assign fall[i] = r_fall;
`else
        assign rise[i] = 1'b0;
        assign fall[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_tt_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_input_debounce
// Description : Self-checking bench for tt_input_debounce (NUM_CH=2,
//               DEBOUNCE_CYCLES=4) against a run-length reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_input_debounce;

    localparam int NUM_CH = 2;
    localparam int D      = 4;
`ifdef DEBOUNCE_EDGE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic              clk    = 1'b0;
    logic              rst    = 1'b1;
    logic [NUM_CH-1:0] raw_in = '0;
    logic [NUM_CH-1:0] db_out;
    logic [NUM_CH-1:0] rise;
    logic [NUM_CH-1:0] fall;
    logic [NUM_CH-1:0] busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: synchronized level is raw delayed two edges; a level
    // differing from the accepted one for D consecutive edges is accepted.
    logic [1:0] m_s1   = '0;
    logic [1:0] m_s2   = '0;
    logic [1:0] m_db   = '0;
    logic [1:0] m_rise = '0;
    logic [1:0] m_fall = '0;
    logic [1:0] m_busy = '0;
    int         m_run[2] = '{0, 0};

    tt_input_debounce #(
        .NUM_CH          (NUM_CH),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .raw_in (raw_in),
        .db_out (db_out),
        .rise   (rise),
        .fall   (fall),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic model_edge(input logic [1:0] raw, input logic r);
        for (int c = 0; c < NUM_CH; c++) begin
            if (r) begin
                m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_db[c] = 1'b0;
                m_rise[c] = 1'b0; m_fall[c] = 1'b0; m_busy[c] = 1'b0;
                m_run[c] = 0;
            end else begin
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (m_s2[c] != m_db[c]) m_run[c] = m_run[c] + 1;
                else                    m_run[c] = 0;
                if (m_run[c] == D) begin
                    m_rise[c] = EDGE_EN & ~m_db[c];
                    m_fall[c] = EDGE_EN & m_db[c];
                    m_db[c]   = ~m_db[c];
                    m_run[c]  = 0;
                end
                m_busy[c] = (m_run[c] != 0);
                m_s2[c]   = m_s1[c];
                m_s1[c]   = raw[c];
            end
        end
    endtask

    task automatic tick(input logic [1:0] raw, input logic r);
        raw_in = raw;
        rst    = r;
        @(posedge clk);
        model_edge(raw, r);
        #1;
    endtask

    function automatic logic [7:0] exp_all();
        return {m_db, m_rise, m_fall, m_busy};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'($urandom), 1'b1);
            n_vec++;
            if ({db_out, rise, fall, busy} !== 8'h00) begin
                n_err++;
                $display("FAIL reset: got %b expected %b", {db_out, rise, fall, busy}, 8'h00);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL reset_idle: got %b expected %b", {db_out, rise, fall, busy}, exp_all());
            end
        end
    endtask

    task automatic test_clean_step();
        int   rises = 0;
        logic [2:0] want;
        for (int k = 1; k <= 9; k++) begin
            tick(2'b01, 1'b0);
            want = {1'(k >= 6), 1'(k >= 3 && k <= 5), EDGE_EN & 1'(k == 6)};
            rises += int'(rise[0]);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL clean_step_model edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
            n_vec++;
            if ({db_out[0], busy[0], rise[0]} !== want) begin
                n_err++;
                $display("FAIL clean_step_timing edge %0d: got db/busy/rise %b expected %b", k, {db_out[0], busy[0], rise[0]}, want);
            end
        end
        n_vec++;
        if (rises != int'(EDGE_EN)) begin
            n_err++;
            $display("FAIL clean_step_rise_count: got %0d expected %0d", rises, int'(EDGE_EN));
        end
        for (int k = 1; k <= 8; k++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL clean_step_release edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 13; k++) begin
            tick((k <= 3) ? 2'b01 : 2'b00, 1'b0);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL glitch_model edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
            n_vec++;
            if ({db_out[0], rise[0]} !== 2'b00) begin
                n_err++;
                $display("FAIL glitch_no_accept edge %0d: got db/rise %b expected 00", k, {db_out[0], rise[0]});
            end
        end
        n_vec++;
        if (busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL glitch_busy_idle: got %b expected 0", busy[0]);
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        for (int c = 0; c < 20; c++) begin
            tick(((c / 2) % 2 == 0) ? 2'b10 : 2'b00, 1'b0);
            rises += int'(rise[1]);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all() || db_out[1] !== 1'b0) begin
                n_err++;
                $display("FAIL bounce_phase cyc %0d: got %b expected %b", c, {db_out, rise, fall, busy}, exp_all());
            end
        end
        for (int k = 1; k <= 9; k++) begin
            tick(2'b10, 1'b0);
            rises += int'(rise[1]);
            n_vec++;
            if (db_out[1] !== 1'(k >= 6) || {db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL bounce_settle edge %0d: got %b expected db1=%0d model %b", k, {db_out, rise, fall, busy}, k >= 6, exp_all());
            end
        end
        n_vec++;
        if (rises != int'(EDGE_EN)) begin
            n_err++;
            $display("FAIL bounce_rise_count: got %0d expected %0d", rises, int'(EDGE_EN));
        end
        for (int k = 1; k <= 8; k++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL bounce_release edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
    endtask

    task automatic test_independence();
        for (int k = 1; k <= 8; k++) begin
            tick(2'b11, 1'b0);
            n_vec++;
            if (db_out !== ((k >= 6) ? 2'b11 : 2'b00) || {db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL indep_both edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
        for (int k = 1; k <= 8; k++) begin
            tick(2'b10, 1'b0);
            n_vec++;
            if (db_out !== ((k >= 6) ? 2'b10 : 2'b11) || fall[0] !== (EDGE_EN & 1'(k == 6)) ||
                {db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL indep_fall0 edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
        for (int k = 1; k <= 8; k++) begin
            tick(2'b00, 1'b0);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL indep_release edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        int rises = 0;
        for (int k = 1; k <= 3; k++) begin
            tick(2'b01, 1'b0);
            rises += int'(rise[0]);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL rst_pend_pre edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
        tick(2'b01, 1'b1);
        n_vec++;
        if ({db_out, rise, fall, busy} !== 8'h00) begin
            n_err++;
            $display("FAIL rst_pend_clear: got %b expected %b", {db_out, rise, fall, busy}, 8'h00);
        end
        for (int k = 1; k <= 9; k++) begin
            tick(2'b01, 1'b0);
            rises += int'(rise[0]);
            n_vec++;
            if (db_out[0] !== 1'(k >= 6) || {db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL rst_pend_post edge %0d: got %b expected %b", k, {db_out, rise, fall, busy}, exp_all());
            end
        end
        n_vec++;
        if (rises != int'(EDGE_EN)) begin
            n_err++;
            $display("FAIL rst_pend_rise_count: got %0d expected %0d", rises, int'(EDGE_EN));
        end
    endtask

    task automatic test_random();
        logic [1:0] v = 2'b00;
        int         hold[2] = '{0, 0};
        logic       r;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (hold[c] == 0) begin
                    v[c]    = 1'($urandom);
                    hold[c] = $urandom_range(1, 7);
                end
                hold[c]--;
            end
            r = ($urandom_range(0, 99) == 0);
            tick(v, r);
            n_vec++;
            if ({db_out, rise, fall, busy} !== exp_all()) begin
                n_err++;
                $display("FAIL random cyc %0d: got %b expected %b", i, {db_out, rise, fall, busy}, exp_all());
            end
            n_vec++;
            if ((rise & fall) !== 2'b00) begin
                n_err++;
                $display("FAIL random_rise_fall_excl cyc %0d: got %b expected 00", i, rise & fall);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_independence();
        test_reset_mid_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tt_input_debounce.md
TT_INPUT_DEBOUNCE -- requirements
Module: tt_input_debounce

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent input channels (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000: consecutive cycles a changed level must persist before acceptance (minimum 2).
REQ-003 clk  input  1  single rising-edge clock; all state SHALL be clocked by clk only.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 raw_in  input  NUM_CH  asynchronous raw button/switch levels (pad side).
REQ-006 db_out  output  NUM_CH  debounced stable levels, registered (logic side, feeds the gate stage).
REQ-007 rise  output  NUM_CH  one-cycle pulse when db_out bit goes 0->1.
REQ-008 fall  output  NUM_CH  one-cycle pulse when db_out bit goes 1->0.
REQ-009 busy  output  NUM_CH  high while a channel has a pending, not-yet-accepted change.

Function
REQ-010 Each channel SHALL pass raw_in through a 2-flop synchronizer (s1, s2) before any other use.
REQ-011 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES); channels SHALL be fully independent.
REQ-012 Per-channel states: STABLE (s2 == db_out, counter 0) and PENDING (s2 != db_out).
REQ-013 STABLE -> PENDING: on a cycle where s2 != db_out, counter increments 0->1.
REQ-014 PENDING: on each edge with s2 != db_out and counter < DEBOUNCE_CYCLES-1, counter increments by 1.
REQ-015 PENDING -> STABLE (accept): on the edge with s2 != db_out and counter == DEBOUNCE_CYCLES-1, db_out bit SHALL invert and counter SHALL clear to 0.
REQ-016 PENDING -> STABLE (reject): on any edge with s2 == db_out, counter SHALL clear to 0 and db_out SHALL hold.
REQ-017 Latency: for a clean step, db_out SHALL change on rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw level into s1 as edge 1.
REQ-018 A raw excursion whose synchronized width is shorter than DEBOUNCE_CYCLES cycles SHALL produce no db_out change.
REQ-019 Counter SHALL never wrap; reaching DEBOUNCE_CYCLES-1 always resolves to accept or reject on the next edge.
REQ-020 busy bit SHALL equal (counter != 0), registered.
REQ-021 rise/fall bits SHALL be registered, asserted in the same cycle db_out shows the new level, and deasserted on the next edge; rise and fall of one channel SHALL never be high together.
REQ-022 Simultaneous changes on several channels SHALL be accepted independently, each at its own REQ-017 latency.

Reset
REQ-023 While rst is high at a rising edge: s1, s2, db_out, counters, rise, fall and busy SHALL all become 0.
REQ-024 Reset asserted mid-PENDING SHALL discard the pending change; no rise/fall pulse SHALL be produced for it.
REQ-025 After rst deasserts with raw_in held high, the channel SHALL accept the high level per REQ-017, counted from the first post-reset edge, and pulse rise once.

Configuration
REQ-026 Macro DEBOUNCE_EDGE_EN: when defined, rise and fall SHALL be generated per REQ-021.
REQ-027 When DEBOUNCE_EDGE_EN is not defined, rise and fall ports SHALL remain present and be driven constant 0, and no edge-detect registers SHALL be implemented; all other behaviour is unchanged.

Verification (DEBOUNCE_CYCLES=4, NUM_CH=2, DEBOUNCE_EDGE_EN defined unless stated)
REQ-028 Clean step: raw_in[0] 0->1 held -> db_out[0]=1 on edge 6, rise[0] high for exactly that one cycle, busy[0] high on edges 3-5.
REQ-029 Glitch: raw_in[0] high for 3 cycles then low -> db_out[0] stays 0, rise[0] never asserts, busy[0] returns to 0.
REQ-030 Bounce: raw_in[1] toggling every 2 cycles for 20 cycles, then held high -> exactly one rise[1], db_out[1]=1 on edge 6 after the final transition.
REQ-031 Independence: raw_in=2'b11 at once -> db_out=2'b11 on the same edge 6; then raw_in[0] low only -> fall[0] pulses and db_out=2'b10.
REQ-032 Reset mid-pending: raw_in[0] high, rst pulsed high on edge 4 -> all outputs 0, then db_out[0]=1 on post-reset edge 6 with a single rise[0].
REQ-033 Macro undefined: repeat REQ-028 -> db_out timing identical, rise and fall constant 0.
